// File: rtl/gpu_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_mem_responder
//  Purpose  : Avalon-MM slave that backs the GPU controller's byte-wide m1
//             master with DEPTH bytes of on-chip memory mapped at BASE_ADDR.
//             Reads return in order after a fixed READ_LATENCY. Writes are
//             accepted in a single cycle. Backpressure is applied through
//             waitrequest when the pending-read limit is reached or when
//             stall is high.
//  Ports    : clock, reset            - single clock, synchronous active-high reset
//             s1_address/writedata    - byte address and write byte
//             s1_write/s1_read        - request strobes, held until accepted
//             s1_waitrequest          - request not accepted this cycle
//             s1_readdata/valid       - returned byte and its one-cycle strobe
//             stall                   - forces waitrequest high
//             err/err_clear           - sticky protocol/range error and its clear
//  Revision : 1.0  initial release
// ============================================================================
module gpu_mem_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          DEPTH        = 4096,
    parameter int          ADDR_BITS    = $clog2(DEPTH),
    parameter int          READ_LATENCY = 2,
    parameter int          MAX_PENDING  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] s1_address,
    input  logic [7:0]  s1_writedata,
    input  logic        s1_write,
    input  logic        s1_read,
    output logic        s1_waitrequest,
    output logic [7:0]  s1_readdata,
    output logic        s1_readdatavalid,
    input  logic        stall,
    output logic        err,
    input  logic        err_clear
);

    localparam int                PEND_W     = $clog2(MAX_PENDING + 1);
    localparam int                LAST       = READ_LATENCY - 1;
    localparam logic [31:0]       c_depth    = 32'(DEPTH);
    localparam logic [PEND_W-1:0] c_max_pend = PEND_W'(MAX_PENDING);

    logic [7:0]              r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [7:0]              r_pipe_data [READ_LATENCY];
    logic [PEND_W-1:0]       r_pending;
    logic                    r_err;

    logic [31:0]             w_addr_diff;
    logic [ADDR_BITS-1:0]    w_offset;
    logic                    w_in_range;
    logic                    w_readdatavalid;
    logic [PEND_W-1:0]       w_pending_eff;
    logic                    w_accept;
    logic                    w_rd_acc;
    logic                    w_wr_acc;
    logic                    w_err_set;
    logic [7:0]              w_rd_byte;

    // Range test on the difference avoids overflow of BASE_ADDR+DEPTH.
    assign w_addr_diff = s1_address - BASE_ADDR;
    assign w_offset    = w_addr_diff[ADDR_BITS-1:0];
    assign w_in_range  = (s1_address >= BASE_ADDR) && (w_addr_diff < c_depth);

    assign w_readdatavalid = r_pipe_vld[LAST];

    // A read returning this cycle frees its slot immediately, so a full
    // pipeline can still accept a new read in the cycle a result leaves.
    assign w_pending_eff = r_pending - PEND_W'(w_readdatavalid);

    // Read+write together is an error accepted like a write, so the
    // pending limit only gates pure reads.
    assign s1_waitrequest = reset | stall |
                            (s1_read & ~s1_write & (w_pending_eff == c_max_pend));

    assign w_accept  = (s1_read | s1_write) & ~s1_waitrequest;
    assign w_rd_acc  = w_accept & s1_read & ~s1_write;
    assign w_wr_acc  = w_accept & s1_write & ~s1_read;
    assign w_err_set = w_accept & ((s1_read & s1_write) | ~w_in_range);
    assign w_rd_byte = w_in_range ? r_mem[w_offset] : 8'h00;

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (w_wr_acc && w_in_range) begin
            r_mem[w_offset] <= s1_writedata;
        end
    end

    // Read data is captured at acceptance, so later writes cannot alter it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_data[i] <= 8'h00;
            end
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pipe_vld[0]  <= w_rd_acc;
            r_pipe_data[0] <= w_rd_acc ? w_rd_byte : 8'h00;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
            end

            case ({w_rd_acc, w_readdatavalid})
                2'b10:   r_pending <= r_pending + PEND_W'(1);
                2'b01:   r_pending <= r_pending - PEND_W'(1);
                default: r_pending <= r_pending;
            endcase

            // A new error wins over a simultaneous clear.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    assign s1_readdatavalid = w_readdatavalid;
    assign s1_readdata      = r_pipe_data[LAST];
    assign err              = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gpu_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpu_mem_responder
//  Purpose  : Scoreboard bench for gpu_mem_responder. Instance A uses the
//             default parameters; instance B uses MAX_PENDING=1 and
//             READ_LATENCY=3 to exercise the pending-read limit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gpu_mem_responder;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;

    logic [31:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_write, b_write, a_read, b_read;
    logic        a_wait, b_wait, a_rdv, b_rdv;
    logic [7:0]  a_rdata, b_rdata;
    logic        a_err, b_err, a_err_clear;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    gpu_mem_responder dut_a (
        .clock(clock), .reset(reset), .s1_address(a_addr), .s1_writedata(a_wdata),
        .s1_write(a_write), .s1_read(a_read), .s1_waitrequest(a_wait),
        .s1_readdata(a_rdata), .s1_readdatavalid(a_rdv), .stall(stall),
        .err(a_err), .err_clear(a_err_clear)
    );

    gpu_mem_responder #(.MAX_PENDING(1), .READ_LATENCY(3)) dut_b (
        .clock(clock), .reset(reset), .s1_address(b_addr), .s1_writedata(b_wdata),
        .s1_write(b_write), .s1_read(b_read), .s1_waitrequest(b_wait),
        .s1_readdata(b_rdata), .s1_readdatavalid(b_rdv), .stall(1'b0),
        .err(b_err), .err_clear(1'b0)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitors: compare each returned byte and its arrival cycle.
    always @(negedge clock) begin
        if (q_a.size() > 0 && q_a[0].due < cyc) begin
            void'(q_a.pop_front());
            fail_now("a_missing_rdv");
        end
        if (a_rdv) begin
            if (q_a.size() == 0) begin
                fail_now("a_unexpected_rdv");
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_rdata", {24'h0, a_rdata}, {24'h0, e.data});
                chk("a_rdv_cycle", cyc, e.due);
            end
        end
    end

    always @(negedge clock) begin
        if (q_b.size() > 0 && q_b[0].due < cyc) begin
            void'(q_b.pop_front());
            fail_now("b_missing_rdv");
        end
        if (b_rdv) begin
            if (q_b.size() == 0) begin
                fail_now("b_unexpected_rdv");
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_rdata", {24'h0, b_rdata}, {24'h0, e.data});
                chk("b_rdv_cycle", cyc, e.due);
            end
        end
    end

    // Drive one request on instance sel (0=A, 1=B), hold until accepted,
    // push the expected read return, then go idle one tick after the edge.
    task automatic req(input bit sel, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [7:0] wd, input logic [7:0] exp_rd, output int acc);
        bit done = 0;
        acc = -1;
        if (sel) begin b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd; end
        else     begin a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd; end
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clock);
            if (!(sel ? b_wait : a_wait)) begin
                done = 1;
                acc  = cyc;
                if (rd && !wr) begin
                    if (sel) q_b.push_back('{data: exp_rd, due: cyc + 3});
                    else     q_a.push_back('{data: exp_rd, due: cyc + 2});
                end
            end
        end
        if (!done) fail_now("accept_timeout");
        @(posedge clock);
        #1;
        if (sel) begin b_read = 0; b_write = 0; end
        else     begin a_read = 0; a_write = 0; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, t;
        reset = 1; stall = 0; a_err_clear = 0;
        a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0;
        b_read = 0; b_write = 0; b_addr = 0; b_wdata = 0;

        // Reset state
        @(negedge clock);
        chk("rst_waitrequest", a_wait, 1);
        chk("rst_rdv", a_rdv, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_err", a_err, 0);
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("idle_waitrequest", a_wait, 0);
        @(posedge clock); #1;

        // Test 1: write then immediate read of the same byte
        req(0, 0, 1, 32'd3, 8'h5A, 8'h00, acc0);
        req(0, 1, 0, 32'd3, 8'h00, 8'h5A, acc1);
        chk("t1_read_accept_cycle", acc1, acc0 + 1);
        repeat (4) @(posedge clock); #1;

        // Test 2: four back-to-back reads return back-to-back in order
        req(0, 0, 1, 32'd0, 8'h11, 8'h00, t);
        req(0, 0, 1, 32'd1, 8'h22, 8'h00, t);
        req(0, 0, 1, 32'd2, 8'h33, 8'h00, t);
        req(0, 0, 1, 32'd3, 8'h44, 8'h00, t);
        req(0, 1, 0, 32'd0, 8'h00, 8'h11, acc0);
        for (int i = 1; i < 4; i++) begin
            logic [7:0] v;
            v = 8'h11 * 8'(i + 1);
            req(0, 1, 0, 32'(i), 8'h00, v, acc1);
            chk("t2_accept_cycle", acc1, acc0 + i);
        end
        repeat (4) @(posedge clock); #1;

        // Test 3 (instance B): pending limit of 1 with latency 3
        req(1, 0, 1, 32'd0, 8'hAB, 8'h00, t);
        req(1, 0, 1, 32'd1, 8'hCD, 8'h00, t);
        req(1, 1, 0, 32'd0, 8'h00, 8'hAB, acc0);
        b_read = 1; b_addr = 32'd1;
        @(negedge clock);
        chk("t3_wait_c1", b_wait, 1);
        @(negedge clock);
        chk("t3_wait_c2", b_wait, 1);
        @(posedge clock); #1;
        req(1, 1, 0, 32'd1, 8'h00, 8'hCD, acc1);
        chk("t3_second_accept", acc1, acc0 + 3);
        @(negedge clock);
        chk("t3_idle_no_wait", b_wait, 0);
        repeat (4) @(posedge clock); #1;

        // Test 4: stall holds off a write for five cycles
        stall = 1; a_write = 1; a_addr = 32'd7; a_wdata = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t4_stalled_wait", a_wait, 1);
            @(posedge clock); #1;
        end
        stall = 0;
        @(negedge clock);
        chk("t4_released_wait", a_wait, 0);
        @(posedge clock); #1;
        a_write = 0;
        req(0, 1, 0, 32'd7, 8'h00, 8'hC3, t);
        repeat (3) @(posedge clock); #1;

        // Test 5: range boundaries and err behaviour
        req(0, 0, 1, 32'd4095, 8'h77, 8'h00, t);
        req(0, 1, 0, 32'd4095, 8'h00, 8'h77, t);
        @(negedge clock);
        chk("t5_err_in_range", a_err, 0);
        @(posedge clock); #1;
        req(0, 1, 0, 32'd4096, 8'h00, 8'h00, t);
        @(negedge clock);
        chk("t5_err_after_oor_read", a_err, 1);
        @(posedge clock); #1 a_err_clear = 1;
        @(posedge clock); #1 a_err_clear = 0;
        @(negedge clock);
        chk("t5_err_cleared", a_err, 0);
        @(posedge clock); #1;
        req(0, 1, 0, 32'hFFFF_FFFF, 8'h00, 8'h00, t);
        @(negedge clock);
        chk("t5_err_top_addr", a_err, 1);
        @(posedge clock); #1 a_err_clear = 1;
        req(0, 0, 1, 32'd4099, 8'hEE, 8'h00, t);
        a_err_clear = 0;
        @(negedge clock);
        chk("t5_set_beats_clear", a_err, 1);
        @(posedge clock); #1 a_err_clear = 1;
        @(posedge clock); #1 a_err_clear = 0;
        req(0, 1, 0, 32'd3, 8'h00, 8'h44, t);

        // Read and write together: nothing performed, err set
        req(0, 1, 1, 32'd0, 8'hFF, 8'h00, t);
        @(negedge clock);
        chk("t5_both_err", a_err, 1);
        @(posedge clock); #1;
        req(0, 1, 0, 32'd0, 8'h00, 8'h11, t);
        repeat (4) @(posedge clock); #1;

        // Test 6: reset flushes an in-flight read, memory survives
        req(0, 1, 0, 32'd1, 8'h00, 8'h22, t);
        reset = 1;
        q_a.delete();
        @(negedge clock);
        chk("t6_wait_in_reset", a_wait, 1);
        chk("t6_rdv_in_reset", a_rdv, 0);
        @(posedge clock); #1 reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t6_no_rdv_after_reset", a_rdv, 0);
        end
        chk("t6_err_after_reset", a_err, 0);
        @(posedge clock); #1;
        req(0, 1, 0, 32'd2, 8'h00, 8'h33, t);
        req(0, 1, 0, 32'd7, 8'h00, 8'hC3, t);
        req(0, 1, 0, 32'd4095, 8'h00, 8'h77, t);

        repeat (8) @(posedge clock);
        @(negedge clock);
        chk("final_queue_a_empty", q_a.size(), 0);
        chk("final_queue_b_empty", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
